tm1637_link_tx: RTL and testbench



---
 rtl/tm1637_pkg.sv | 90 +++++++++
 rtl/tm1637_link_tx_if.sv | 21 ++
 rtl/tm1637_phase_tick.sv | 33 +++
 rtl/tm1637_link_tx.sv | 158 +++++++++++++++
 tb/tb_tm1637_link_tx.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/tm1637_pkg.sv
// Shared types, phase counts and command constants for the TM1637 link transmitter.
package tm1637_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESTOP,
    START,
    BIT,
    ACK,
    ACK2,
    STOP
  } state_e;

  typedef struct packed {
    logic clk;
    logic oe;
  } pins_t;

  localparam int unsigned PRESTOP_PHASES = 3;
  localparam int unsigned START_PHASES   = 3;
  localparam int unsigned BIT_PHASES     = 2;
  localparam int unsigned ACK_PHASES     = 2;
  localparam int unsigned ACK2_PHASES    = 1;
  localparam int unsigned STOP_PHASES    = 3;

  localparam logic [7:0] DATA_AUTOINC = 8'h40;
  localparam logic [7:0] ADDR_BASE    = 8'hC0;
  localparam logic [7:0] DISP_ON      = 8'h88;
  localparam logic [7:0] DISP_OFF     = 8'h80;

  function automatic logic [7:0] dispOnCmd(input logic [2:0] brightness);
    return DISP_ON | {5'b0, brightness};
  endfunction

  function automatic logic [1:0] lastPhase(input state_e s);
    logic [1:0] last;
    last = 2'd0;
    case (s)
      PRESTOP: last = 2'(PRESTOP_PHASES - 1);
      START:   last = 2'(START_PHASES - 1);
      BIT:     last = 2'(BIT_PHASES - 1);
      ACK:     last = 2'(ACK_PHASES - 1);
      ACK2:    last = 2'(ACK2_PHASES - 1);
      STOP:    last = 2'(STOP_PHASES - 1);
      default: last = 2'd0;
    endcase
    return last;
  endfunction

  // Pin levels for a non-idle phase; idle levels depend on framing and live in the top.
  function automatic pins_t phasePins(input state_e s, input logic [1:0] ph, input logic bitVal);
    pins_t p;
    p.clk = 1'b1;
    p.oe  = 1'b0;
    case (s)
      PRESTOP, STOP: begin
        case (ph)
          2'd0:    begin p.clk = 1'b0; p.oe = 1'b1; end
          2'd1:    begin p.clk = 1'b1; p.oe = 1'b1; end
          default: begin p.clk = 1'b1; p.oe = 1'b0; end
        endcase
      end
      START: begin
        case (ph)
          2'd0:    begin p.clk = 1'b1; p.oe = 1'b0; end
          2'd1:    begin p.clk = 1'b1; p.oe = 1'b1; end
          default: begin p.clk = 1'b0; p.oe = 1'b1; end
        endcase
      end
      BIT: begin
        p.clk = ph[0];
        p.oe  = ~bitVal;
      end
      ACK: begin
        p.clk = ph[0];
        p.oe  = 1'b0;
      end
      ACK2: begin
        p.clk = 1'b0;
        p.oe  = 1'b0;
      end
      default: begin
        p.clk = 1'b1;
        p.oe  = 1'b0;
      end
    endcase
    return p;
  endfunction

endpackage

// File: rtl/tm1637_link_tx_if.sv
// Byte handshake between the display step sequencer (master) and the link transmitter (slave).
interface tm1637_link_tx_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_stop;
  logic       busy;
  logic       done;
  logic       ack_err;

  modport master (
    output tx_valid, tx_data, tx_start, tx_stop,
    input  tx_ready, busy, done, ack_err
  );

  modport slave (
    input  tx_valid, tx_data, tx_start, tx_stop,
    output tx_ready, busy, done, ack_err
  );
endinterface

// File: rtl/tm1637_phase_tick.sv
// Link phase timer: counts CLK_DIV clk cycles per phase and flags the last one.
module tm1637_phase_tick #(
  parameter int CLK_DIV = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic tick_o
);

  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] count_q, count_d;

  assign tick_o = (count_q == LAST);

  always_comb begin
    count_d = count_q + W'(1);
    if (clear_i || tick_o) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tm1637_link_tx.sv
// TM1637 bit-level transmitter: start/prestop framing, 8 bits LSB first, ACK slot, stop.
// Optional macro TM1637_ACK_CHECK_EN enables sampling DIO in the ACK slot for ack_err.
module tm1637_link_tx
  import tm1637_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic                   clk,
  input  logic                   rst,
  tm1637_link_tx_if.slave        txIf,
  output logic                   tm_clk,
  output logic                   tm_dio_oe,
  input  logic                   tm_dio_in
);

  state_e     state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic [2:0] bitIdx_q, bitIdx_d;
  logic [7:0] data_q, data_d;
  logic       stop_q, stop_d;
  logic       inFrame_q, inFrame_d;
  logic       tmClk_q, tmClk_d;
  logic       dioOe_q, dioOe_d;
  logic       done_q, done_d;
  logic       ackErr_q, ackErr_d;
  logic       ackSample_q, ackSample_d;
  logic       tick;
  logic       tickClear;
  pins_t      pins;

  tm1637_phase_tick #(.CLK_DIV(CLK_DIV)) uTick (
    .clk     (clk),
    .rst     (rst),
    .clear_i (tickClear),
    .tick_o  (tick)
  );

`ifndef TM1637_ACK_CHECK_EN
  logic unusedDio;
  assign unusedDio = tm_dio_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      bitIdx_q    <= '0;
      data_q      <= '0;
      stop_q      <= 1'b0;
      inFrame_q   <= 1'b0;
      tmClk_q     <= 1'b1;
      dioOe_q     <= 1'b0;
      done_q      <= 1'b0;
      ackErr_q    <= 1'b0;
      ackSample_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bitIdx_q    <= bitIdx_d;
      data_q      <= data_d;
      stop_q      <= stop_d;
      inFrame_q   <= inFrame_d;
      tmClk_q     <= tmClk_d;
      dioOe_q     <= dioOe_d;
      done_q      <= done_d;
      ackErr_q    <= ackErr_d;
      ackSample_q <= ackSample_d;
    end
  end

  // Pins are computed from the next state so they change on the same edge as the phase.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bitIdx_d    = bitIdx_q;
    data_d      = data_q;
    stop_d      = stop_q;
    inFrame_d   = inFrame_q;
    done_d      = 1'b0;
    ackErr_d    = 1'b0;
    ackSample_d = ackSample_q;
    tickClear   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (txIf.tx_valid) begin
          data_d    = txIf.tx_data;
          stop_d    = txIf.tx_stop;
          phase_d   = '0;
          bitIdx_d  = '0;
          tickClear = 1'b1;
          if (txIf.tx_start) begin
            state_d = inFrame_q ? PRESTOP : START;
          end else begin
            state_d = BIT;
          end
        end
      end
      default: begin
        if (tick) begin
          if (phase_q != lastPhase(state_q)) begin
            phase_d = phase_q + 2'd1;
          end else begin
            phase_d = '0;
            case (state_q)
              PRESTOP: state_d = START;
              START: begin
                state_d   = BIT;
                inFrame_d = 1'b1;
              end
              BIT: begin
                if (bitIdx_q == 3'd7) begin
                  state_d = ACK;
                end else begin
                  bitIdx_d = bitIdx_q + 3'd1;
                end
              end
              ACK: begin
                state_d = stop_q ? STOP : ACK2;
`ifdef TM1637_ACK_CHECK_EN
                ackSample_d = tm_dio_in;
`endif
              end
              ACK2: begin
                state_d  = IDLE;
                done_d   = 1'b1;
                ackErr_d = ackSample_q;
              end
              STOP: begin
                state_d   = IDLE;
                inFrame_d = 1'b0;
                done_d    = 1'b1;
                ackErr_d  = ackSample_q;
              end
              default: state_d = IDLE;
            endcase
          end
        end
      end
    endcase

    pins    = phasePins(state_d, phase_d, data_d[bitIdx_d]);
    tmClk_d = pins.clk;
    dioOe_d = pins.oe;
    if (state_d == IDLE) begin
      tmClk_d = ~inFrame_d;
      dioOe_d = 1'b0;
    end
  end

  assign txIf.tx_ready = (state_q == IDLE);
  assign txIf.busy     = (state_q != IDLE);
  assign txIf.done     = done_q;
  assign txIf.ack_err  = ackErr_q;
  assign tm_clk        = tmClk_q;
  assign tm_dio_oe     = dioOe_q;

endmodule

// File: tb/tb_tm1637_link_tx.sv
// Self-checking bench for tm1637_link_tx with CLK_DIV=4 and a phase-list reference model.
// Honours TM1637_ACK_CHECK_EN for the expected ack_err value.
module tb_tm1637_link_tx;

  localparam int D = 4;

  logic clk;
  logic rst;
  logic tm_clk;
  logic tm_dio_oe;
  logic tm_dio_in;

  int compared   = 0;
  int mismatched = 0;

  bit         modelInFrame = 1'b0;
  logic [1:0] expPhases[$];

  tm1637_link_tx_if txIf ();

  tm1637_link_tx #(.CLK_DIV(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .txIf      (txIf),
    .tm_clk    (tm_clk),
    .tm_dio_oe (tm_dio_oe),
    .tm_dio_in (tm_dio_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected (tm_clk, tm_dio_oe) per phase, derived from the framing rules.
  task automatic buildPhases(input logic [7:0] d, input bit start, input bit stop);
    expPhases.delete();
    if (start && modelInFrame) begin
      expPhases.push_back(2'b01);
      expPhases.push_back(2'b11);
      expPhases.push_back(2'b10);
    end
    if (start) begin
      expPhases.push_back(2'b10);
      expPhases.push_back(2'b11);
      expPhases.push_back(2'b01);
      modelInFrame = 1'b1;
    end
    for (int i = 0; i < 8; i++) begin
      expPhases.push_back({1'b0, ~d[i]});
      expPhases.push_back({1'b1, ~d[i]});
    end
    expPhases.push_back(2'b00);
    expPhases.push_back(2'b10);
    if (stop) begin
      expPhases.push_back(2'b01);
      expPhases.push_back(2'b11);
      expPhases.push_back(2'b10);
      modelInFrame = 1'b0;
    end else begin
      expPhases.push_back(2'b00);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("idlePins",
                  8'({tm_clk, tm_dio_oe, txIf.tx_ready, txIf.busy, txIf.done, txIf.ack_err}),
                  8'({~modelInFrame, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle with tx_valid dropped.
  task automatic applyStimulus(input logic [7:0] d, input bit start, input bit stop,
                               input bit dioHigh, input bit scramble, input int abortPhase);
    int         nCyc;
    logic [1:0] ph;
    bit         expAck;
    checkOutput("readyBeforeAccept", 8'(txIf.tx_ready), 8'd1);
    txIf.tx_valid = 1'b1;
    txIf.tx_data  = d;
    txIf.tx_start = start;
    txIf.tx_stop  = stop;
    tm_dio_in     = dioHigh;
    buildPhases(d, start, stop);
`ifdef TM1637_ACK_CHECK_EN
    expAck = dioHigh;
`else
    expAck = 1'b0;
`endif
    nCyc = expPhases.size() * D;
    @(posedge clk);
    for (int c = 1; c <= nCyc; c++) begin
      @(negedge clk);
      ph = expPhases[(c - 1) / D];
      checkOutput("pinsDuringByte",
                  8'({tm_clk, tm_dio_oe, txIf.done, txIf.tx_ready}),
                  8'({ph, 2'b00}));
      if ((c - 1) / D == abortPhase) begin
        rst           = 1'b1;
        txIf.tx_valid = 1'b0;
        @(negedge clk);
        checkOutput("afterReset",
                    8'({tm_clk, tm_dio_oe, txIf.tx_ready, txIf.busy, txIf.done, txIf.ack_err}),
                    8'b0010_1000);
        rst          = 1'b0;
        modelInFrame = 1'b0;
        return;
      end
      if (scramble) begin
        txIf.tx_valid = 1'($urandom_range(0, 1));
        txIf.tx_data  = 8'($urandom);
        txIf.tx_start = 1'($urandom_range(0, 1));
        txIf.tx_stop  = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    checkOutput("doneCycle",
                8'({txIf.done, txIf.ack_err, txIf.tx_ready, tm_clk, tm_dio_oe}),
                8'({1'b1, expAck, 1'b1, ~modelInFrame, 1'b0}));
    txIf.tx_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    bit         rs, rp, rh, rx;
    rst           = 1'b1;
    tm_dio_in     = 1'b1;
    txIf.tx_valid = 1'b0;
    txIf.tx_data  = 8'h00;
    txIf.tx_start = 1'b0;
    txIf.tx_stop  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetState",
                8'({tm_clk, tm_dio_oe, txIf.tx_ready, txIf.busy, txIf.done, txIf.ack_err}),
                8'b0010_1000);
    rst = 1'b0;
    idleCycles(2);

    $display("[TB] 8F start+stop, ACK low then high");
    applyStimulus(8'h8F, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    idleCycles(2);
    applyStimulus(8'h8F, 1'b1, 1'b1, 1'b1, 1'b0, -1);
    idleCycles(2);

    $display("[TB] back-to-back 40/C0/3F");
    applyStimulus(8'h40, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus(8'hC0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus(8'h3F, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    idleCycles(2);

    $display("[TB] restart inside a frame");
    applyStimulus(8'h40, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    idleCycles(1);
    applyStimulus(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus(8'h12, 1'b1, 1'b1, 1'b1, 1'b0, -1);
    idleCycles(2);

    $display("[TB] reset during bit 3");
    applyStimulus(8'hB6, 1'b1, 1'b1, 1'b0, 1'b0, 9);
    idleCycles(3);
    applyStimulus(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    idleCycles(1);

    $display("[TB] inputs disturbed while busy");
    applyStimulus(8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, -1);
    idleCycles(2);

    $display("[TB] randomized bytes");
    for (int k = 0; k < 8; k++) begin
      rd = 8'($urandom);
      rs = 1'($urandom_range(0, 1));
      rp = 1'($urandom_range(0, 1));
      rh = 1'($urandom_range(0, 1));
      rx = 1'($urandom_range(0, 1));
      applyStimulus(rd, rs, rp, rh, rx, -1);
      idleCycles(int'($urandom_range(0, 2)));
    end
    if (modelInFrame) begin
      applyStimulus(dispOnCmdTb(3'd7), 1'b0, 1'b1, 1'b0, 1'b0, -1);
    end
    idleCycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  function automatic logic [7:0] dispOnCmdTb(input logic [2:0] b);
    return 8'h88 | {5'b0, b};
  endfunction

endmodule
